pll_lock_rst_seq: RTL and testbench

- Consumes the asynchronous LOCK output of the TMDS clock PLL.
- Synchronises and qualifies lock, then releases the serialiser-domain and pixel-domain resets in a fixed order.
- Detects loss of lock and re-arms the sequence. On lock timeout it pulses a PLL reset request and retries.
- Runs on the 27 MHz crystal clock, which feeds the PLL; sits between the PLL instance and the HDMI TX/video pipeline reset inputs.

---
 rtl/pll_lock_rst_seq_pkg.sv | 44 ++++
 rtl/pll_lock_rst_seq_sync2_bit.sv | 35 +++
 rtl/pll_lock_rst_seq.sv | 161 ++++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_rst_seq_pkg
// Purpose : Shared types and default constants for the PLL lock / reset
//           sequencer (state encoding, default cycle counts).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pll_lock_rst_seq_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUAL      = 3'd2,
    REL_SER   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // Default cycle counts for a 27 MHz reference clock.
  localparam int unsigned C_STABLE_CYC  = 1024;
  localparam int unsigned C_GAP_CYC     = 16;
  localparam int unsigned C_TIMEOUT_CYC = 2700000;
  localparam int unsigned C_PLLRST_CYC  = 27;
  localparam int unsigned C_CNT_W       = 8;

  // Floor on the shared cycle counter width.
  localparam int unsigned C_SEQ_CNT_MIN_W = 22;

  // Largest of the four cycle parameters; sizes the shared counter.
  function automatic int unsigned cyc_max(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c,
                                          input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_rst_seq_sync2_bit.sv
`default_nettype none
// ============================================================================
// Module  : sync2_bit
// Purpose : Two-flop synchroniser for a single asynchronous status input.
//           Both flops reset to 0 asynchronously.
// Ports   : I_clk   - destination clock
//           I_rst_n - asynchronous active-low reset
//           I_d     - asynchronous input
//           O_q     - synchronised output (2-cycle latency)
// Revision: 1.0 - initial release
// ============================================================================
module sync2_bit (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_d,
  output logic O_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= I_d;
      r_sync <= r_meta;
    end
  end

  assign O_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_rst_seq
// Purpose : Qualifies the asynchronous PLL LOCK, releases the serialiser and
//           pixel domain resets in order, re-arms on loss of lock and pulses
//           a PLL reset request on lock timeout.
// Ports   : I_clk       - 27 MHz reference clock
//           I_rst_n     - asynchronous active-low reset
//           I_pll_lock  - PLL LOCK, asynchronous to I_clk
//           O_pll_rst   - active-high PLL reset request
//           O_rst_ser_n - active-low serialiser/TMDS domain reset
//           O_rst_pix_n - active-low pixel domain reset
//           O_ready     - high while running
//           O_loss_cnt  - saturating count of lock-loss events
//           O_timeout   - sticky lock-timeout flag
// Revision: 1.0 - initial release
// ============================================================================
module pll_lock_rst_seq
  import pll_lock_rst_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = C_STABLE_CYC,
  parameter int unsigned GAP_CYC     = C_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC,
  parameter int unsigned PLLRST_CYC  = C_PLLRST_CYC,
  parameter int unsigned CNT_W       = C_CNT_W
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_pll_lock,
  output logic             O_pll_rst,
  output logic             O_rst_ser_n,
  output logic             O_rst_pix_n,
  output logic             O_ready,
  output logic [CNT_W-1:0] O_loss_cnt,
  output logic             O_timeout
);

  localparam int unsigned CYC_MAX = cyc_max(STABLE_CYC, GAP_CYC, TIMEOUT_CYC, PLLRST_CYC);
  localparam int unsigned CW      = ($clog2(CYC_MAX) > C_SEQ_CNT_MIN_W) ?
                                    $clog2(CYC_MAX) : C_SEQ_CNT_MIN_W;

  // Terminal counts: the counter holds 0 in the first cycle of a state.
  localparam logic [CW-1:0] c_pllrst_last  = CW'(PLLRST_CYC - 1);
  localparam logic [CW-1:0] c_timeout_last = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] c_stable_last  = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] c_gap_last     = CW'(GAP_CYC - 1);

  logic             w_lk_s;
  state_t           r_state;
  state_t           w_state_d;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_d;
  logic             w_loss;
  logic             w_timeout_evt;

  logic             r_pll_rst;
  logic             r_rst_ser_n;
  logic             r_rst_pix_n;
  logic             r_ready;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             r_timeout;

  sync2_bit u_lock_sync (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_d     (I_pll_lock),
    .O_q     (w_lk_s)
  );

  // State and shared cycle counter.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= PLL_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_loss        = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == c_pllrst_last) w_state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lk_s) begin
          w_state_d = QUAL;
        end else if (r_cnt == c_timeout_last) begin
          w_state_d     = PLL_RST;
          w_timeout_evt = 1'b1;
        end
      end
      QUAL: begin
        // Any low cycle restarts qualification from WAIT_LOCK; not a loss.
        if (!w_lk_s) begin
          w_state_d = WAIT_LOCK;
        end else if (r_cnt == c_stable_last) begin
          w_state_d = REL_SER;
        end
      end
      REL_SER: begin
        // Lock loss takes priority over completing the release gap.
        if (!w_lk_s) begin
          w_state_d = WAIT_LOCK;
          w_loss    = 1'b1;
        end else if (r_cnt == c_gap_last) begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (!w_lk_s) begin
          w_state_d = WAIT_LOCK;
          w_loss    = 1'b1;
        end
      end
      default: w_state_d = PLL_RST;
    endcase

    // Clear on every state entry; idle in RUN where no timing is needed.
    if ((w_state_d != r_state) || (r_state == RUN)) begin
      w_cnt_d = '0;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // the state does, one cycle after the condition is seen on the synced lock.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pll_rst   <= 1'b1;
      r_rst_ser_n <= 1'b0;
      r_rst_pix_n <= 1'b0;
      r_ready     <= 1'b0;
      r_loss_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_pll_rst   <= (w_state_d == PLL_RST);
      r_rst_ser_n <= (w_state_d == REL_SER) || (w_state_d == RUN);
      r_rst_pix_n <= (w_state_d == RUN);
      r_ready     <= (w_state_d == RUN);
      if (w_timeout_evt) r_timeout <= 1'b1;
      if (w_loss && (r_loss_cnt != {CNT_W{1'b1}})) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end
  end

  assign O_pll_rst   = r_pll_rst;
  assign O_rst_ser_n = r_rst_ser_n;
  assign O_rst_pix_n = r_rst_pix_n;
  assign O_ready     = r_ready;
  assign O_loss_cnt  = r_loss_cnt;
  assign O_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_lock_rst_seq
// Purpose : Self-checking bench for pll_lock_rst_seq. The stimulus process
//           queues every expected output change (cycle + output vector); the
//           monitor pops one entry whenever the outputs change.
//           Output vector = {pll_rst, rst_ser_n, rst_pix_n, ready, timeout,
//           loss_cnt[1:0]}.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pll_lock_rst_seq;

  localparam int unsigned STABLE_CYC  = 8;
  localparam int unsigned GAP_CYC     = 4;
  localparam int unsigned TIMEOUT_CYC = 50;
  localparam int unsigned PLLRST_CYC  = 3;
  localparam int unsigned CNT_W       = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             lock  = 1'b1;
  logic             pll_rst;
  logic             ser_n;
  logic             pix_n;
  logic             ready;
  logic             timeout;
  logic [CNT_W-1:0] loss_cnt;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  int         q_cyc[$];
  logic [6:0] q_vec[$];
  string      q_name[$];

  pll_lock_rst_seq #(
    .STABLE_CYC  (STABLE_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .PLLRST_CYC  (PLLRST_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_pll_lock  (lock),
    .O_pll_rst   (pll_rst),
    .O_rst_ser_n (ser_n),
    .O_rst_pix_n (pix_n),
    .O_ready     (ready),
    .O_loss_cnt  (loss_cnt),
    .O_timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] mk(input logic p, input logic s, input logic x,
                                    input logic t, input int c);
    logic [1:0] cc;
    cc = 2'(c);
    return {p, s, x, x, t, cc};
  endfunction

  task automatic expect_at(input int c, input logic [6:0] v, input string nm);
    q_cyc.push_back(c);
    q_vec.push_back(v);
    q_name.push_back(nm);
  endtask

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------- monitor
  logic [6:0] m_prev;
  logic [6:0] m_cur;
  bit         m_first = 1'b1;
  int         m_ecyc;
  logic [6:0] m_evec;
  string      m_name;

  initial begin : monitor
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      m_cur = {pll_rst, ser_n, pix_n, ready, timeout, loss_cnt};
      n_chk++;
      if ((pix_n && !ser_n) || (ready != pix_n) || (pll_rst && (ser_n || pix_n))) begin
        $display("FAIL invariant: cyc=%0d got vec=%b, required pix->ser, ready==pix, pll_rst->resets held",
                 cyc, m_cur);
      end else begin
        n_pass++;
      end
      if (m_first || (m_cur != m_prev)) begin
        n_chk++;
        if (q_cyc.size() == 0) begin
          $display("FAIL unexpected_change: cyc=%0d got vec=%b, required no change from %b",
                   cyc, m_cur, m_prev);
        end else begin
          m_ecyc = q_cyc.pop_front();
          m_evec = q_vec.pop_front();
          m_name = q_name.pop_front();
          if ((m_ecyc != cyc) || (m_evec != m_cur)) begin
            $display("FAIL %s: got cyc=%0d vec=%b, required cyc=%0d vec=%b",
                     m_name, cyc, m_cur, m_ecyc, m_evec);
          end else begin
            n_pass++;
          end
        end
      end
      m_prev  = m_cur;
      m_first = 1'b0;
    end
  end

  // --------------------------------------------------------------- stimulus
  int b;
  int sat;

  initial begin : stimulus
    expect_at(0, mk(1, 0, 0, 0, 0), "reset_state");
    #1 rst_n = 1'b0;
    step(3);

    // First bring-up, interrupted by an async reset while in REL_SER.
    rst_n = 1'b1;
    b = cyc;
    expect_at(b + 3,  mk(0, 0, 0, 0, 0), "first_pll_rst_drop");
    expect_at(b + 12, mk(0, 1, 0, 0, 0), "first_ser_release");
    step(14);
    b = cyc;
    expect_at(b, mk(1, 0, 0, 0, 0), "async_reset_in_rel_ser");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // Normal bring-up: 3 PLL_RST + 1 WAIT_LOCK + 8 QUAL, then 4-cycle gap.
    expect_at(b + 3,  mk(0, 0, 0, 0, 0), "bringup_pll_rst_drop");
    expect_at(b + 12, mk(0, 1, 0, 0, 0), "bringup_ser_release");
    expect_at(b + 16, mk(0, 1, 1, 0, 0), "bringup_pix_release");
    step(20);

    // Loss in RUN for 20 cycles: teardown 3 edges after the drop.
    b = cyc;
    lock = 1'b0;
    expect_at(b + 3, mk(0, 0, 0, 0, 1), "run_loss_teardown");
    step(20);
    lock = 1'b1;
    expect_at(b + 31, mk(0, 1, 0, 0, 1), "relock_ser_release");
    expect_at(b + 35, mk(0, 1, 1, 0, 1), "relock_pix_release");
    step(18);

    // Fresh reset, then a one-cycle lock glitch at qualification count 5.
    b = cyc;
    expect_at(b, mk(1, 0, 0, 0, 0), "reset_before_glitch");
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    b = cyc;
    expect_at(b + 3,  mk(0, 0, 0, 0, 0), "glitch_pll_rst_drop");
    expect_at(b + 19, mk(0, 1, 0, 0, 0), "glitch_ser_release");
    expect_at(b + 23, mk(0, 1, 1, 0, 0), "glitch_pix_release");
    step(7);
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(20);

    // Five losses: a 2-bit counter reads 1, 2, 3, 3, 3.
    for (int i = 1; i <= 5; i++) begin
      sat = (i > 3) ? 3 : i;
      b = cyc;
      lock = 1'b0;
      expect_at(b + 3, mk(0, 0, 0, 0, sat), "sat_loss");
      step(4);
      lock = 1'b1;
      expect_at(b + 15, mk(0, 1, 0, 0, sat), "sat_ser_release");
      expect_at(b + 19, mk(0, 1, 1, 0, sat), "sat_pix_release");
      step(16);
    end

    // Timeout: lock held low, PLL reset every 3 + 50 cycles.
    b = cyc;
    lock = 1'b0;
    expect_at(b + 3,   mk(0, 0, 0, 0, 3), "timeout_loss");
    expect_at(b + 53,  mk(1, 0, 0, 1, 3), "timeout1_pll_rst");
    expect_at(b + 56,  mk(0, 0, 0, 1, 3), "timeout1_pll_rst_drop");
    expect_at(b + 106, mk(1, 0, 0, 1, 3), "timeout2_pll_rst");
    expect_at(b + 109, mk(0, 0, 0, 1, 3), "timeout2_pll_rst_drop");
    step(112);

    n_chk++;
    if (q_cyc.size() != 0) begin
      $display("FAIL pending_events: got %0d unmatched, first %s at cyc=%0d, required 0",
               q_cyc.size(), q_name[0], q_cyc[0]);
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
